fast_axis_tpg: RTL and testbench



---
 rtl/fast_tpg_pkg.sv | 31 +++
 rtl/fast_tpg_lfsr.sv | 28 ++
 rtl/fast_axis_tpg.sv | 217 +++++++++++++++++++++
 tb/tb_fast_axis_tpg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_tpg_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern generator.
// Optional source bubbles are enabled with the FAST_TPG_STALL_EN macro.
package fast_tpg_pkg;

   typedef enum logic [1:0] {StIdle, StLine, StHblank, StFrameEnd} tpg_state_e;

   localparam logic [1:0]  PAT_HRAMP = 2'd0;
   localparam logic [1:0]  PAT_VRAMP = 2'd1;
   localparam logic [1:0]  PAT_CHECK = 2'd2;
   localparam logic [1:0]  PAT_NOISE = 2'd3;

   localparam logic [10:0] MIN_DIM   = 11'd2;

   // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [7:0] pattern_pixel(input logic [1:0]  pat,
                                                input logic [10:0] x,
                                                input logic [10:0] y,
                                                input logic [7:0]  noise);
      logic [7:0] pix;
      case (pat)
         PAT_HRAMP: pix = x[7:0];
         PAT_VRAMP: pix = y[7:0];
         PAT_CHECK: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
         default:   pix = noise;
      endcase
      return pix;
   endfunction

endpackage

// File: rtl/fast_tpg_lfsr.sv
// 16-bit Fibonacci LFSR with reset seed and advance enable.
// Exposes both the current state and the value it advances to.
module fast_tpg_lfsr
   import fast_tpg_pkg::*;
#(
   parameter logic [15:0] Seed = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic [15:0] state_o,
   output logic [15:0] next_o
);

   logic [15:0] lfsr_q;

   assign next_o  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   assign state_o = lfsr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= Seed;
      end else if (en_i) begin
         lfsr_q <= next_o;
      end
   end

endmodule

// File: rtl/fast_axis_tpg.sv
// AXI4-Stream video test-pattern generator: frames with TUSER/TLAST and hblank gaps.
// Define FAST_TPG_STALL_EN to insert pseudo-random source bubbles between beats.
module fast_axis_tpg
   import fast_tpg_pkg::*;
#(
   parameter int unsigned data_depth = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  ACLK_in,
   input  logic                  ARESET_in,
   input  logic                  TPG_EN,
   input  logic [10:0]           width_in,
   input  logic [10:0]           height_in,
   input  logic [1:0]            pattern_sel,
   input  logic [7:0]            hblank_in,
   output logic [data_depth-1:0] TDATA_out,
   output logic                  TSTRB_out,
   output logic                  TLAST_out,
   output logic                  TVALID_out,
   output logic                  TUSER_out,
   input  logic                  TREADY_in,
   output logic                  frame_done
);

   tpg_state_e            state_q, state_d;
   logic [10:0]           x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [1:0]            pat_q, pat_d;
   logic [7:0]            hb_q, hb_d, hcnt_q, hcnt_d;
   logic                  last_q, last_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
   logic                  done_q, done_d;
   logic [data_depth-1:0] tdata_q, tdata_d;
   logic                  accept, load_beat, pix_adv;
   logic [15:0]           pix_lfsr, pix_next;
   logic                  unused_pix;

   assign accept = tvalid_q & TREADY_in;

   fast_tpg_lfsr #(.Seed(LFSR_SEED)) u_pix_lfsr (
      .clk_i   (ACLK_in),
      .rst_i   (ARESET_in),
      .en_i    (pix_adv),
      .state_o (pix_lfsr),
      .next_o  (pix_next)
   );

   assign unused_pix = ^{pix_lfsr[15:8], pix_next[15:8]};

`ifdef FAST_TPG_STALL_EN
   logic [2:0]  stall_q, stall_d;
   logic [15:0] stall_lfsr, stall_next;
   logic        unused_stall;

   // Separate generator so bubbles never perturb the noise pattern
   fast_tpg_lfsr #(.Seed({LFSR_SEED[7:0], LFSR_SEED[15:8]})) u_stall_lfsr (
      .clk_i   (ACLK_in),
      .rst_i   (ARESET_in),
      .en_i    (accept | (stall_q != 3'd0)),
      .state_o (stall_lfsr),
      .next_o  (stall_next)
   );

   assign unused_stall = ^{stall_lfsr, stall_next[11:2]};
`endif

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      w_d       = w_q;
      h_d       = h_q;
      pat_d     = pat_q;
      hb_d      = hb_q;
      hcnt_d    = hcnt_q;
      last_d    = last_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tuser_d   = tuser_q;
      tdata_d   = tdata_q;
      done_d    = 1'b0;
      load_beat = 1'b0;
      pix_adv   = 1'b0;
`ifdef FAST_TPG_STALL_EN
      stall_d   = stall_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (TPG_EN) begin
               w_d       = (width_in < MIN_DIM) ? MIN_DIM : width_in;
               h_d       = (height_in < MIN_DIM) ? MIN_DIM : height_in;
               pat_d     = pattern_sel;
               hb_d      = hblank_in;
               x_d       = 11'd0;
               y_d       = 11'd0;
               state_d   = StLine;
               load_beat = 1'b1;
            end
         end
         StLine: begin
            if (accept) begin
               pix_adv = 1'b1;
               if (x_q == w_q - 11'd1) begin
                  last_d   = (y_q == h_q - 11'd1);
                  x_d      = 11'd0;
                  y_d      = last_d ? y_q : y_q + 11'd1;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tuser_d  = 1'b0;
                  if (hb_q != 8'd0) begin
                     state_d = StHblank;
                     hcnt_d  = hb_q;
                  end else if (last_d) begin
                     state_d = StFrameEnd;
                     done_d  = 1'b1;
                  end else begin
                     load_beat = 1'b1;
                  end
               end else begin
                  x_d = x_q + 11'd1;
`ifdef FAST_TPG_STALL_EN
                  if (stall_next[15:12] == 4'hF) begin
                     stall_d  = 3'd1 + {1'b0, stall_next[1:0]};
                     tvalid_d = 1'b0;
                  end else begin
                     load_beat = 1'b1;
                  end
`else
                  load_beat = 1'b1;
`endif
               end
            end
`ifdef FAST_TPG_STALL_EN
            else if (stall_q != 3'd0) begin
               stall_d = stall_q - 3'd1;
               if (stall_q == 3'd1) begin
                  load_beat = 1'b1;
               end
            end
`endif
         end
         StHblank: begin
            if (hcnt_q == 8'd1) begin
               if (last_q) begin
                  state_d = StFrameEnd;
                  done_d  = 1'b1;
               end else begin
                  state_d   = StLine;
                  load_beat = 1'b1;
               end
            end else begin
               hcnt_d = hcnt_q - 8'd1;
            end
         end
         StFrameEnd: begin
            state_d = StIdle;
         end
      endcase

      // Register the next beat; noise uses the LFSR value as of that beat
      if (load_beat) begin
         tvalid_d = 1'b1;
         tuser_d  = (x_d == 11'd0) && (y_d == 11'd0);
         tlast_d  = (x_d == w_d - 11'd1);
         tdata_d  = data_depth'(pattern_pixel(pat_d, x_d, y_d,
                                              pix_adv ? pix_next[7:0] : pix_lfsr[7:0]));
      end
   end

   always_ff @(posedge ACLK_in) begin
      if (ARESET_in) begin
         state_q  <= StIdle;
         x_q      <= 11'd0;
         y_q      <= 11'd0;
         w_q      <= MIN_DIM;
         h_q      <= MIN_DIM;
         pat_q    <= PAT_HRAMP;
         hb_q     <= 8'd0;
         hcnt_q   <= 8'd0;
         last_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         tdata_q  <= '0;
         done_q   <= 1'b0;
`ifdef FAST_TPG_STALL_EN
         stall_q  <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         w_q      <= w_d;
         h_q      <= h_d;
         pat_q    <= pat_d;
         hb_q     <= hb_d;
         hcnt_q   <= hcnt_d;
         last_q   <= last_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         tdata_q  <= tdata_d;
         done_q   <= done_d;
`ifdef FAST_TPG_STALL_EN
         stall_q  <= stall_d;
`endif
      end
   end

   assign TDATA_out  = tdata_q;
   assign TSTRB_out  = tvalid_q;
   assign TLAST_out  = tlast_q;
   assign TVALID_out = tvalid_q;
   assign TUSER_out  = tuser_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fast_axis_tpg.sv
// Self-checking bench for fast_axis_tpg: frame-level model plus directed checks.
module tb_fast_axis_tpg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        tready = 1'b1;
   logic [10:0] width = 11'd4;
   logic [10:0] height = 11'd2;
   logic [1:0]  pat = 2'd0;
   logic [7:0]  hblank = 8'd0;
   logic [7:0]  tdata;
   logic        tstrb, tlast, tvalid, tuser, done;

   always #5 clk = ~clk;

   fast_axis_tpg #(.data_depth(8), .LFSR_SEED(16'hACE1)) dut (
      .ACLK_in     (clk),
      .ARESET_in   (rst),
      .TPG_EN      (en),
      .width_in    (width),
      .height_in   (height),
      .pattern_sel (pat),
      .hblank_in   (hblank),
      .TDATA_out   (tdata),
      .TSTRB_out   (tstrb),
      .TLAST_out   (tlast),
      .TVALID_out  (tvalid),
      .TUSER_out   (tuser),
      .TREADY_in   (tready),
      .frame_done  (done)
   );

   int          total = 0;
   int          bad = 0;
   logic [9:0]  exp_q[$];  // {data, tuser, tlast}
   logic [9:0]  log_q[$];
   logic [9:0]  e, held;
   logic [15:0] mlfsr = 16'hACE1;
   int          cyc = 0, done_cnt = 0, done_cyc = 0, hs_cyc = 0;
   int          stall_seen = 0, exp_gap = 0, gap = 0, target = 0;
   logic        in_gap = 1'b0, hold = 1'b0, rand_ready = 1'b0;
   logic [7:0]  stall_data = 8'd0;
   logic [7:0]  t1_exp [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
   logic [7:0]  uv, lv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Expected beats of one frame, in raster order
   task automatic start_frame(input int w, input int h, input int p, input int hb);
      int ww, hh;
      logic [7:0] d;
      logic u, l;
      width = 11'(w);
      height = 11'(h);
      pat = 2'(p);
      hblank = 8'(hb);
      ww = (w < 2) ? 2 : w;
      hh = (h < 2) ? 2 : h;
      log_q.delete();
      for (int yy = 0; yy < hh; yy++) begin
         for (int xx = 0; xx < ww; xx++) begin
            case (p)
               0:       d = 8'(xx % 256);
               1:       d = 8'(yy % 256);
               2:       d = ((xx / 8 + yy / 8) % 2 == 1) ? 8'hFF : 8'h00;
               default: d = mlfsr[7:0];
            endcase
            mlfsr = lfsr_step(mlfsr);
            u = (xx == 0 && yy == 0);
            l = (xx == ww - 1);
            exp_q.push_back({d, u, l});
         end
      end
      target = done_cnt + 1;
   endtask

   task automatic pulse_en();
      @(posedge clk); #1 en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int c = 0;
      while (done_cnt < target && c < limit) begin
         @(posedge clk);
         c++;
      end
      check("frame_done_seen", done_cnt, target);
   endtask

   task automatic wait_log(input int n);
      int c = 0;
      while (log_q.size() < n && c < 200) begin
         @(posedge clk);
         c++;
      end
      check("beats_reached", log_q.size(), n);
   endtask

   function automatic int count_flag(input int b);
      int n = 0;
      foreach (log_q[i]) if (log_q[i][b]) n++;
      return n;
   endfunction

   initial forever begin
      @(posedge clk); #1;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
   end

   // Every-cycle compare against the frame model
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         hold = 1'b0;
         in_gap = 1'b0;
      end else begin
         check("tstrb_eq_tvalid", tstrb, tvalid);
         if (hold) begin
            check("hold_valid", tvalid, 1);
            check("hold_beat", {tdata, tuser, tlast}, held);
         end
         if (in_gap && tvalid) begin
            if (!tuser) check("hblank_gap", gap, exp_gap);
            in_gap = 1'b0;
         end else if (in_gap) begin
            gap++;
         end
         if (tvalid && !tready) begin
            stall_seen++;
            stall_data = tdata;
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got %0h want none", {tdata, tuser, tlast});
            end else begin
               e = exp_q.pop_front();
               check("beat", {tdata, tuser, tlast}, e);
            end
            log_q.push_back({tdata, tuser, tlast});
            hs_cyc = cyc;
            if (tlast) begin
               in_gap = 1'b1;
               gap = 0;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         hold = tvalid && !tready;
         held = {tdata, tuser, tlast};
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {tdata, tstrb, tlast, tvalid, tuser, done}, 0);
      rst = 1'b0;

      // 4x2 h-ramp, single EN pulse; inputs changed mid-frame must be ignored
      start_frame(4, 2, 0, 0);
      pulse_en();
      width = 11'd9;
      pat = 2'd1;
      wait_done(100);
      repeat (5) @(posedge clk);
      check("t1_handshakes", log_q.size(), 8);
      uv = '0;
      lv = '0;
      for (int i = 0; i < log_q.size() && i < 8; i++) begin
         check("t1_data", log_q[i][9:2], t1_exp[i]);
         uv[i] = log_q[i][1];
         lv[i] = log_q[i][0];
      end
      check("t1_tuser", uv, 8'b0000_0001);
      check("t1_tlast", lv, 8'b1000_1000);
      check("t1_done_latency", done_cyc - hs_cyc, 1);

      // Same frame, beat 3 backpressured for 5 cycles
      start_frame(4, 2, 0, 0);
      stall_seen = 0;
      pulse_en();
      wait_log(2);
      #1 tready = 1'b0;
      repeat (5) @(posedge clk);
      #1 tready = 1'b1;
      wait_done(100);
      check("t2_stall_cycles", stall_seen, 5);
      check("t2_stall_data", stall_data, 8'h02);
      check("t2_handshakes", log_q.size(), 8);
      for (int i = 0; i < log_q.size() && i < 8; i++) check("t2_data", log_q[i][9:2], t1_exp[i]);

      // 16x16 checker with 3-cycle hblank
      exp_gap = 3;
      start_frame(16, 16, 2, 3);
      pulse_en();
      wait_done(1000);
      exp_gap = 0;
      check("t3_handshakes", log_q.size(), 256);
      if (log_q.size() == 256) begin
         check("t3_px_8_0", log_q[8][9:2], 8'hFF);
         check("t3_px_0_8", log_q[128][9:2], 8'hFF);
         check("t3_px_8_8", log_q[136][9:2], 8'h00);
      end

      // 4x4 v-ramp, EN dropped while beat 5 is presented
      start_frame(4, 4, 1, 0);
      @(posedge clk); #1 en = 1'b1;
      wait_log(4);
      #1 en = 1'b0;
      wait_done(100);
      repeat (10) @(posedge clk);
      check("t4_handshakes", log_q.size(), 16);
      check("t4_tuser_count", count_flag(1), 1);
      check("t4_no_restart", done_cnt, target);
      if (log_q.size() == 16) check("t4_last_px", log_q[15][9:2], 8'd3);

      // Reset while beat 3 of a 4x2 frame is presented, EN held high
      start_frame(4, 2, 0, 0);
      @(posedge clk); #1 en = 1'b1;
      wait_log(2);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("t5_reset_outputs", {tdata, tstrb, tlast, tvalid, tuser, done}, 0);
      exp_q.delete();
      mlfsr = 16'hACE1;
      start_frame(4, 2, 0, 0);
      rst = 1'b0;
      wait_done(100);
      #1 en = 1'b0;
      repeat (5) @(posedge clk);
      check("t5_handshakes", log_q.size(), 8);
      if (log_q.size() > 0) check("t5_first_beat", log_q[0], 10'b0000_0000_10);

      // Clamp: 1x0 becomes 2x2
      start_frame(1, 0, 0, 0);
      pulse_en();
      wait_done(100);
      repeat (3) @(posedge clk);
      check("t6_clamped_beats", log_q.size(), 4);

      // Noise from a fresh seed, random TREADY, hblank 2
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      mlfsr = 16'hACE1;
      exp_gap = 2;
      start_frame(32, 8, 3, 2);
      rand_ready = 1'b1;
      pulse_en();
      wait_done(3000);
      #1 rand_ready = 1'b0;
      tready = 1'b1;
      repeat (3) @(posedge clk);
      check("t7_handshakes", log_q.size(), 256);
      check("t7_tlast_count", count_flag(0), 8);
      check("t7_tuser_count", count_flag(1), 1);
      if (log_q.size() >= 3) begin
         check("t7_noise0", log_q[0][9:2], 8'hE1);
         check("t7_noise1", log_q[1][9:2], 8'hC3);
         check("t7_noise2", log_q[2][9:2], 8'h87);
      end
      check("model_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
